uart_tx_ctrl: RTL
=================

Name: uart_tx_ctrl

Overview:
Control unit for the UART transmitter. It accepts bytes from the host over a valid/ready handshake and buffers them in a small FIFO. For each byte it builds the 11-bit frame and sequences the existing PISO shifter through piso_start, active_flag and done_flag. The block sits between the host interface and the PISO, and runs entirely on baud_clk.

Parameters:
FIFO_DEPTH, 4, byte FIFO entries; power of two, 2..16.
GAP_CYCLES, 1, baud_clk cycles piso_start is held low between frames; minimum 1.
TIMEOUT_CYCLES, 32, cycles in WAIT_DONE without done_flag before the frame is aborted.

Ports:
baud_clk  in  1  sole clock.
rst  in  1  synchronous reset, active-high.
tx_data  in  8  host byte.
tx_valid  in  1  host byte valid.
tx_ready  out  1  FIFO not full; a transfer happens when tx_valid&&tx_ready.
parity_en  in  1  1 = parity bit in frame[9]; 0 = frame[9] is 1 (second stop bit).
parity_odd  in  1  1 = odd parity, 0 = even parity.
data_frame  out  11  frame to the PISO.
piso_start  out  1  PISO enable, held high for the whole frame.
active_flag  in  1  PISO transmitting.
done_flag  in  1  PISO frame complete; pulse or level.
busy  out  1  FIFO non-empty or state != IDLE.
tx_error  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Frame format: frame[0]=0 (start), frame[8:1]=data with LSB in frame[1], frame[9]=parity or 1, frame[10]=1 (stop).
- Parity: even = XOR of the data bits; odd = its inverse. parity_en and parity_odd are sampled in LOAD only; changes mid-frame have no effect.
- Reset values: data_frame=11'h7FF (idle-high line), piso_start=0, tx_ready=1, busy=0, tx_error=0. The FIFO is emptied and the state is IDLE.
- State IDLE: if the FIFO is non-empty, pop the head byte and go to LOAD.
- State LOAD: register data_frame from the popped byte, then go to START.
- State START: drive piso_start=1, clear the timeout counter, go to WAIT_DONE.
- State WAIT_DONE:
  - piso_start stays 1 and data_frame stays stable.
  - On the first cycle done_flag=1, drive piso_start=0 and go to GAP.
  - If the counter reaches TIMEOUT_CYCLES, pulse tx_error, drive piso_start=0 and go to GAP.
  - active_flag is used only for the assertion check below; it does not alter the flow.
- State GAP: hold piso_start=0 for GAP_CYCLES cycles, then go to IDLE. data_frame keeps the last frame.
- Latency: a byte accepted into an empty FIFO while IDLE raises piso_start 3 cycles after the handshake cycle. The path is 1 cycle to FIFO visibility, then LOAD, then START.
- Back-to-back frames: piso_start low time between frames is GAP_CYCLES+2 cycles (GAP, then IDLE/LOAD).
- A done_flag held as a level across GAP is ignored because it is not sampled outside WAIT_DONE. A stale done_flag on the first WAIT_DONE cycle is accepted as done; this is a documented PISO requirement that done_flag drops once piso_start is low.
- FIFO full: tx_ready=0 and tx_valid is ignored.
- Simultaneous push and pop:
  - When full: the pop happens, but the push is still refused, because tx_ready is registered from the full flag.
  - When empty: the push lands and the pop does not occur that cycle.
- Pointers wrap modulo FIFO_DEPTH; occupancy counter width is clog2(FIFO_DEPTH)+1.
- Reset mid-frame: piso_start drops on the next edge and queued bytes are discarded.
- Assertion: if active_flag=1 while piso_start=0 for more than 2 cycles, flag a protocol error in simulation only.

Decomposition:
- Shared package uart_pkg: FRAME_W=11, DATA_W=8, START_BIT=1'b0, STOP_BIT=1'b1, IDLE_FRAME=11'h7FF, FSM state enum (IDLE, LOAD, START, WAIT_DONE, GAP), and a parity function.
- Sub-module tx_byte_fifo: synchronous FIFO with push/pop, full/empty and head data; parameterised by FIFO_DEPTH.
- The FSM and frame builder stay in uart_tx_ctrl.

Test Plan:
- Reset, then push 0xA5 with parity_en=1, parity_odd=0 -> data_frame=11'h54A; piso_start rises 3 cycles after the handshake. Pulse done_flag -> piso_start falls next cycle.
- Push 0x01 with even parity, then 0x01 with odd parity, parity changed between pushes -> frames 11'h602 then 11'h402.
- parity_en=0, push 0xFF -> data_frame=11'h7FE.
- Push 5 bytes with done_flag never asserted and FIFO_DEPTH=4:
  - tx_ready=0 once 4 are queued.
  - tx_error pulses after 32 WAIT_DONE cycles and the next byte starts.
  - All bytes drain in order.
- Back-to-back frames with done_flag held high 3 cycles -> each frame sent exactly once; piso_start low for 3 cycles between frames.
- Assert rst during WAIT_DONE with 2 bytes queued -> piso_start=0, data_frame=11'h7FF, busy=0 next cycle; no further frames.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   FRAME_W / DATA_W   : frame and payload widths
//   START_BIT/STOP_BIT : line levels of the framing bits
//   IDLE_FRAME         : all-ones frame that keeps the line idle-high
//   state_t            : transmit controller states
//   calc_parity        : parity bit for a payload byte
//   build_frame        : assembles the 11-bit frame, LSB (start bit) first
package uart_pkg;

  localparam int FRAME_W = 11;
  localparam int DATA_W  = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam logic [FRAME_W-1:0] IDLE_FRAME = 11'h7FF;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_DONE,
    GAP
  } state_t;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic calc_parity(input logic [DATA_W-1:0] data,
                                       input logic              odd);
    return (^data) ^ odd;
  endfunction

  // Without parity, bit 9 becomes a second stop bit.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [DATA_W-1:0] data,
                                                     input logic              parity_en,
                                                     input logic              parity_odd);
    logic bit9;
    bit9 = parity_en ? calc_parity(data, parity_odd) : STOP_BIT;
    return {STOP_BIT, bit9, data, START_BIT};
  endfunction

endpackage

// File: rtl/tx_byte_fifo.sv
// Synchronous byte FIFO between the host handshake and the frame sequencer.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push       : write push_data when not full (ignored when full)
//   push_data  : byte to enqueue
//   pop        : discard head byte when not empty (ignored when empty)
//   head_data  : byte at the head of the queue
//   full/empty : occupancy flags decoded from the registered count
module tx_byte_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              push_ok;
  logic              pop_ok;

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign head_data = mem[rd_ptr];

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: buffers host bytes, builds each 11-bit frame and
// sequences the PISO shifter through piso_start / done_flag.
//   baud_clk     : sole clock
//   rst          : synchronous active-high reset
//   tx_data/tx_valid/tx_ready : host byte handshake (transfer on valid&&ready)
//   parity_en, parity_odd     : frame options, sampled once per frame in LOAD
//   data_frame   : frame presented to the PISO (idle-high when nothing sent)
//   piso_start   : held high from START through WAIT_DONE
//   active_flag  : PISO transmitting (protocol monitoring only)
//   done_flag    : PISO frame complete, pulse or level
//   busy         : bytes queued or a frame in progress
//   tx_error     : one-cycle pulse when a frame is aborted on timeout
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int GAP_CYCLES     = 1,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic               baud_clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  input  logic               parity_en,
  input  logic               parity_odd,
  output logic [FRAME_W-1:0] data_frame,
  output logic               piso_start,
  input  logic               active_flag,
  input  logic               done_flag,
  output logic               busy,
  output logic               tx_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_ctrl: FIFO_DEPTH must be a power of two in 2..16");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("uart_tx_ctrl: GAP_CYCLES must be at least 1");
  end

  state_t            state;
  state_t            next_state;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic [DATA_W-1:0] byte_p0;
  logic [TW-1:0]     tmo_cnt;
  logic [GW-1:0]     gap_cnt;
  logic              abort;
  logic              orphan_active;

  tx_byte_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (baud_clk),
    .rst       (rst),
    .push      (tx_valid),
    .push_data (tx_data),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Ready comes from the registered occupancy, so a pop in the same cycle
  // does not open the FIFO to a push until the following cycle.
  assign tx_ready = !fifo_full;
  assign busy     = !fifo_empty || (state != IDLE);

  always_comb begin
    next_state = state;
    fifo_pop   = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          next_state = LOAD;
        end
      end
      LOAD:  next_state = START;
      START: next_state = WAIT_DONE;
      WAIT_DONE: begin
        if (done_flag) begin
          next_state = GAP;
        end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          abort      = 1'b1;
          next_state = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GW'(GAP_CYCLES - 1)) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Stage p0: byte captured as it leaves the FIFO head.
  always_ff @(posedge baud_clk) begin
    if (fifo_pop) byte_p0 <= fifo_head;
  end

  // Stage p1: frame register and PISO control.
  always_ff @(posedge baud_clk) begin
    if (rst) begin
      state      <= IDLE;
      piso_start <= 1'b0;
      tx_error   <= 1'b0;
      data_frame <= IDLE_FRAME;
      tmo_cnt    <= '0;
      gap_cnt    <= '0;
    end else begin
      state      <= next_state;
      piso_start <= (next_state == START) || (next_state == WAIT_DONE);
      tx_error   <= abort;
      if (state == LOAD) begin
        data_frame <= build_frame(byte_p0, parity_en, parity_odd);
      end
      if (state == START)          tmo_cnt <= '0;
      else if (state == WAIT_DONE) tmo_cnt <= tmo_cnt + TW'(1);
      if (state == GAP) gap_cnt <= gap_cnt + GW'(1);
      else              gap_cnt <= '0;
    end
  end

  // The PISO must not keep transmitting long after it has been released.
  assign orphan_active = active_flag && !piso_start;

  a_active_released : assert property (@(posedge baud_clk) disable iff (rst)
    !(orphan_active && $past(orphan_active, 1) && $past(orphan_active, 2)))
    else $error("uart_tx_ctrl: active_flag high with piso_start low for more than 2 cycles");

endmodule
